// File: rtl/gps_pkg.sv
// Shared GPS constants and the correlator state encoding used by the
// upsampler, the correlator and the tracking-loop blocks.
package gps_pkg;

  localparam int CA_CODE_LEN = 16800;
  localparam int CA_RATE_INC = 1021613;

  typedef enum logic [1:0] {
    CORR_IDLE  = 2'd0,
    CORR_ARMED = 2'd1,
    CORR_RUN   = 2'd2
  } corr_state_t;

endpackage

// File: rtl/ca_corr_tap.sv
// One correlator arm: signed accumulate of +/-sample, with the period total
// (including the dump sample) captured into a result register one cycle later.
module ca_corr_tap #(
  parameter int SAMPLE_WIDTH = 4,
  parameter int ACC_WIDTH    = 20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  input  logic                    i_bit,
  input  logic                    i_load,
  input  logic                    i_add,
  input  logic                    i_dump,
  output logic [ACC_WIDTH-1:0]    o_result
);

  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] r_result;

  assign w_ext  = {{(ACC_WIDTH-SAMPLE_WIDTH){i_sample[SAMPLE_WIDTH-1]}}, i_sample};
  assign w_prod = i_bit ? w_ext : -w_ext;
  // A period-start sample replaces the running sum, so no clear cycle is needed.
  assign w_sum  = i_load ? w_prod : (r_acc + w_prod);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      if (i_load || i_add) r_acc <= w_sum;
      if (i_dump)          r_result <= w_sum;
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/ca_correlator.sv
// Early/prompt/late C/A correlator over one code period; results appear one cycle
// after the last-sample dump and are held (valid/ready) until accepted, sticky overrun.
module ca_correlator
  import gps_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 4,
  parameter int ACC_WIDTH    = 20,
  parameter int EL_SPACING   = 8,
  parameter int CODE_LEN     = CA_CODE_LEN
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    sample_valid,
  input  logic                    code_in,
  input  logic [14:0]             code_shift,
  input  logic                    start,
  input  logic                    stop,
  output logic [ACC_WIDTH-1:0]    acc_early,
  output logic [ACC_WIDTH-1:0]    acc_prompt,
  output logic [ACC_WIDTH-1:0]    acc_late,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic                    overrun
);

  localparam int          DLY_LEN    = 2 * EL_SPACING;
  localparam logic [14:0] LAST_SHIFT = 15'(CODE_LEN - 1);

  corr_state_t        r_state;
  logic [DLY_LEN-1:0] r_dly;
  logic               r_vld;
  logic               r_ovr;
  logic               w_first;
  logic               w_last;
  logic               w_run_smp;
  logic               w_load;
  logic               w_add;
  logic               w_dump;

  assign w_first   = (code_shift == 15'd0);
  assign w_last    = (code_shift == LAST_SHIFT);
  // stop aborts the period outright, including a coincident dump sample.
  assign w_run_smp = sample_valid && !stop &&
                     ((r_state == CORR_RUN) || ((r_state == CORR_ARMED) && w_first));
  assign w_load    = w_run_smp && w_first;
  assign w_add     = w_run_smp && !w_first;
  assign w_dump    = w_run_smp && (r_state == CORR_RUN) && w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CORR_IDLE;
    end else if (stop) begin
      r_state <= CORR_IDLE;
    end else begin
      case (r_state)
        CORR_IDLE:  if (start) r_state <= CORR_ARMED;
        CORR_ARMED: if (sample_valid && w_first) r_state <= CORR_RUN;
        CORR_RUN:   r_state <= CORR_RUN;
        default:    r_state <= CORR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dly <= '0;
    end else if (sample_valid) begin
      r_dly <= {r_dly[DLY_LEN-2:0], code_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_dump) begin
        r_vld <= 1'b1;
        if (r_vld && !acc_ready) r_ovr <= 1'b1;
      end else if (r_vld && acc_ready) begin
        r_vld <= 1'b0;
      end
    end
  end

  ca_corr_tap #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_early (
    .clk(clk), .reset_n(reset_n), .i_sample(sample), .i_bit(code_in),
    .i_load(w_load), .i_add(w_add), .i_dump(w_dump), .o_result(acc_early)
  );

  ca_corr_tap #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_prompt (
    .clk(clk), .reset_n(reset_n), .i_sample(sample), .i_bit(r_dly[EL_SPACING-1]),
    .i_load(w_load), .i_add(w_add), .i_dump(w_dump), .o_result(acc_prompt)
  );

  ca_corr_tap #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_late (
    .clk(clk), .reset_n(reset_n), .i_sample(sample), .i_bit(r_dly[DLY_LEN-1]),
    .i_load(w_load), .i_add(w_add), .i_dump(w_dump), .o_result(acc_late)
  );

  assign acc_valid = r_vld;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_ca_correlator.sv
// Directed bench for ca_correlator: full-period runs, short periods built from
// code_shift jumps, handshake/overrun table, impulse tap alignment and stop/start.
module tb_ca_correlator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  sample = '0;
  logic        sample_valid = 1'b0;
  logic        code_in = 1'b0;
  logic [14:0] code_shift = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [19:0] acc_early;
  logic [19:0] acc_prompt;
  logic [19:0] acc_late;
  logic        acc_valid;
  logic        acc_ready = 1'b0;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic v;
    int   smp;
    logic code;
    int   sh;
    logic rdy;
    logic e_vld;
    int   e_acc;
    logic e_ovr;
  } vec_t;

  vec_t vecs[9];

  ca_correlator dut (
    .clk(clk), .reset_n(reset_n), .sample(sample), .sample_valid(sample_valid),
    .code_in(code_in), .code_shift(code_shift), .start(start), .stop(stop),
    .acc_early(acc_early), .acc_prompt(acc_prompt), .acc_late(acc_late),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int e_vld, input int e_e,
                         input int e_p, input int e_l, input int e_ovr);
    int a_e, a_p, a_l;
    a_e = $signed(acc_early);
    a_p = $signed(acc_prompt);
    a_l = $signed(acc_late);
    chk({name, ".valid"},   int'(acc_valid), e_vld);
    chk({name, ".early"},   a_e, e_e);
    chk({name, ".prompt"},  a_p, e_p);
    chk({name, ".late"},    a_l, e_l);
    chk({name, ".overrun"}, int'(overrun), e_ovr);
  endtask

  task automatic step(input logic v, input int smp, input logic c, input int sh);
    sample_valid = v;
    sample       = smp[3:0];
    code_in      = c;
    code_shift   = sh[14:0];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    stop = 1'b0;
    acc_ready = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // handshake / overrun vectors; code 0 everywhere so every tap sees -sample
    vecs[0] = '{1'b1, 2, 1'b0, 0,     1'b1, 1'b0, 50400, 1'b0};
    vecs[1] = '{1'b1, 2, 1'b0, 16799, 1'b0, 1'b1, -4,    1'b0};
    vecs[2] = '{1'b1, 2, 1'b0, 0,     1'b0, 1'b1, -4,    1'b0};
    vecs[3] = '{1'b1, 3, 1'b0, 16799, 1'b1, 1'b1, -5,    1'b0};
    vecs[4] = '{1'b1, 1, 1'b0, 0,     1'b0, 1'b1, -5,    1'b0};
    vecs[5] = '{1'b0, 7, 1'b1, 16799, 1'b0, 1'b1, -5,    1'b0};
    vecs[6] = '{1'b1, 1, 1'b0, 16799, 1'b0, 1'b1, -2,    1'b1};
    vecs[7] = '{1'b0, 0, 1'b0, 0,     1'b1, 1'b0, -2,    1'b1};
    vecs[8] = '{1'b0, 0, 1'b0, 0,     1'b0, 1'b0, -2,    1'b1};

    // ---- 1: reset state, then reset asserted mid-RUN
    do_reset();
    chk_out("reset", 0, 0, 0, 0, 0);
    start = 1'b1; step(1'b0, 0, 1'b0, 0); start = 1'b0;
    step(1'b1, 5, 1'b1, 0);
    step(1'b1, 5, 1'b1, 16799);
    chk_out("t1_dump1", 1, 10, -10, -10, 0);
    step(1'b1, 5, 1'b1, 0);
    step(1'b1, 5, 1'b1, 16799);
    chk_out("t1_dump2", 1, 10, -10, -10, 1);
    step(1'b1, 5, 1'b1, 0);
    step(1'b1, 5, 1'b1, 1);
    #2 reset_n = 1'b0;
    #1 chk_out("t1_async_rst", 0, 0, 0, 0, 0);
    #2 reset_n = 1'b1;
    step(1'b1, 5, 1'b1, 2);
    step(1'b1, 5, 1'b1, 16799);
    chk_out("t1_no_dump", 0, 0, 0, 0, 0);

    // ---- 2: +1 samples, code 1, delay line pre-filled with 8 ones
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 0, 1'b1, 100);
    start = 1'b1; step(1'b0, 0, 1'b0, 0); start = 1'b0;
    for (int sh = 0; sh < 16799; sh++) step(1'b1, 1, 1'b1, sh);
    chk("t2_pre_dump_valid", int'(acc_valid), 0);
    step(1'b1, 1, 1'b1, 16799);
    chk_out("t2_dump", 1, 16800, 16800, 16784, 0);

    // ---- 3: stop, start mid-period (not dumped), then two full periods of -3 / code 0
    acc_ready = 1'b1;
    stop = 1'b1; step(1'b0, 0, 1'b0, 0); stop = 1'b0;
    chk_out("t3_after_stop", 0, 16800, 16800, 16784, 0);
    start = 1'b1; step(1'b1, -3, 1'b0, 16780); start = 1'b0;
    for (int sh = 16781; sh < 16800; sh++) step(1'b1, -3, 1'b0, sh);
    chk_out("t3_armed_no_dump", 0, 16800, 16800, 16784, 0);
    for (int p = 0; p < 2; p++) begin
      for (int sh = 0; sh < 16800; sh++) step(1'b1, -3, 1'b0, sh);
      chk_out($sformatf("t3_period%0d", p), 1, 50400, 50400, 50400, 0);
    end

    // ---- 4: handshake table (short periods via code_shift jumps)
    for (int i = 0; i < 9; i++) begin
      acc_ready = vecs[i].rdy;
      step(vecs[i].v, vecs[i].smp, vecs[i].code, vecs[i].sh);
      chk_out($sformatf("t4_vec%0d", i), int'(vecs[i].e_vld), vecs[i].e_acc,
              vecs[i].e_acc, vecs[i].e_acc, int'(vecs[i].e_ovr));
    end

    // ---- 5: 50% sample_valid, single +7 impulse at valid index 20
    do_reset();
    start = 1'b1; step(1'b0, 0, 1'b0, 0); start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step(1'b1, (i == 20) ? 7 : 0, (i != 12), (i == 24) ? 16799 : i);
      if (i < 24) begin
        step(1'b0, 7, (i == 12), 16799);
        if (i == 10 || i == 23) chk($sformatf("t5_no_dump_%0d", i), int'(acc_valid), 0);
      end
    end
    chk_out("t5_impulse", 1, 7, -7, 7, 0);

    // ---- 6: stop+start at shift 9000 -> IDLE, no dump; re-arm and run a full period
    acc_ready = 1'b1; step(1'b0, 0, 1'b1, 0); acc_ready = 1'b0;
    for (int sh = 0; sh <= 20; sh++) step(1'b1, 1, 1'b1, sh);
    stop = 1'b1; start = 1'b1;
    step(1'b1, 1, 1'b1, 9000);
    stop = 1'b0; start = 1'b0;
    for (int sh = 9001; sh <= 9010; sh++) step(1'b1, 1, 1'b1, sh);
    step(1'b1, 1, 1'b1, 16799);
    chk_out("t6_stopped", 0, 7, -7, 7, 0);
    start = 1'b1; step(1'b0, 1, 1'b1, 0); start = 1'b0;
    for (int sh = 0; sh < 16799; sh++) step(1'b1, 1, 1'b1, sh);
    chk("t6_pre_dump_valid", int'(acc_valid), 0);
    step(1'b1, 1, 1'b1, 16799);
    chk_out("t6_rearm_dump", 1, 16800, 16800, 16800, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
